// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI bridge: FSM state encoding,
// AXI id values used to tag the request owner, and access size codes.
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's sram-like fetch and load/store ports onto a single AXI
// master with one transaction outstanding. Data requests win arbitration.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a request; addr_ok is combinational here only
// ST_AR   | read address offered (arvalid) until arready
// ST_R    | rready held until rvalid; read data captured
// ST_AW_W | awvalid/wvalid offered, each dropped after its own handshake
// ST_B    | bready held until bvalid
// ST_RESP | one-cycle data_ok pulse to the request owner
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, state_next;
  logic        owner_data;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        aw_done;
  logic        w_done;
  logic        accept_data;
  logic        accept_inst;

  // Byte-lane strobes from access size and low address bits.
  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: wstrb_of = 4'b0001 << off;
      SIZE_HALF: wstrb_of = 4'b0011 << off;
      default:   wstrb_of = 4'b1111;
    endcase
  endfunction

  // Arbitration: accept only in IDLE and never while reset is applied; data wins.
  always_comb begin
    accept_data = 1'b0;
    accept_inst = 1'b0;
    if (state == ST_IDLE && !rst) begin
      accept_data = data_req;
      accept_inst = inst_req && !data_req;
    end
  end

  assign data_addr_ok = accept_data;
  assign inst_addr_ok = accept_inst;

  assign arid   = owner_data ? DATA_ID : INST_ID;
  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_of(size_q, addr_q[1:0]);

  assign inst_rdata = rdata_q;
  assign data_rdata = rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and channel handshake outputs.
  always_comb begin
    state_next   = state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_data)      state_next = data_wr ? ST_AW_W : ST_AR;
        else if (accept_inst) state_next = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) state_next = ST_RESP;
      end
      ST_AW_W: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_next = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) state_next = ST_RESP;
      end
      ST_RESP: begin
        data_data_ok = owner_data;
        inst_data_ok = !owner_data;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, independent AW/W completion flags and read data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_data <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      if (accept_data) begin
        owner_data <= 1'b1;
        size_q     <= data_size;
        addr_q     <= data_addr;
        wdata_q    <= data_wdata;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end else if (accept_inst) begin
        owner_data <= 1'b0;
        size_q     <= SIZE_WORD;
        addr_q     <= inst_addr;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      if (rready && rvalid)   rdata_q <= rdata;
    end
  end

endmodule
